// File: rtl/bl_pkg.sv
// Shared types and sizes for the bitline write sequencer slice.
// Opcode and FSM state encodings live here so the bench and RTL agree.
package bl_pkg;

    localparam int NUM_LANES = 8;
    localparam int NUM_BL    = 32;
    localparam int ADDR_W    = $clog2(NUM_BL);
    localparam int CODE_W    = 8;
    localparam int LANE_W    = $clog2(NUM_LANES);

    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_LOAD   = 2'b01,
        OP_PRE_OP = 2'b10,
        OP_BURST  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_PRE,
        S_WRITE,
        S_DONE
    } state_e;

endpackage

// File: rtl/bl_dac_code_bank.sv
// Eight-lane DAC code register file plus the "codes changed" dirty flag.
// Dirty is set by any code write and cleared once settling has completed.
module bl_dac_code_bank
    import bl_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              we,
    input  logic [LANE_W-1:0]                 lane,
    input  logic [CODE_W-1:0]                 code,
    input  logic                              dirty_set,
    input  logic                              dirty_clr,
    output logic [NUM_LANES-1:0][CODE_W-1:0]  codes,
    output logic                              dirty
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            codes <= '0;
        end else if (we) begin
            codes[lane] <= code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty <= 1'b0;
        end else if (dirty_set) begin
            dirty <= 1'b1;
        end else if (dirty_clr) begin
            dirty <= 1'b0;
        end
    end

endmodule

// File: rtl/bl_write_sequencer.sv
// Command sequencer driving bitline pre-op/address strobes with DAC settling.
// Optional abort support is compiled in with BL_SEQ_ABORT_EN.
module bl_write_sequencer
    import bl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [1:0]                        cmd_op,
    input  logic [LANE_W-1:0]                 cmd_lane,
    input  logic [CODE_W-1:0]                 cmd_code,
    input  logic [ADDR_W-1:0]                 cmd_addr,
    input  logic [ADDR_W-1:0]                 cmd_len,
    output logic [NUM_LANES-1:0][CODE_W-1:0]  dac_code,
    output logic                              bl_pre_op_en,
    output logic                              bl_addr_en,
    output logic [ADDR_W-1:0]                 addr,
    output logic                              busy,
`ifdef BL_SEQ_ABORT_EN
    input  logic                              cmd_abort,
    output logic                              abort_ack,
`endif
    output logic                              done
);

    localparam logic [CNT_W-1:0] SETTLE_LD =
        CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_e            state;
    state_e            state_nx;
    op_e               op;
    logic              xfer;
    logic              run_cmd;
    logic              dirty;
    logic              need_settle;
    logic              settle_clr;
    logic              abort_req;
    logic              abort_hit;
    logic [CNT_W-1:0]  cnt;
    logic              lat_burst;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] rem;

    logic              pre_d;
    logic              wr_d;
    logic              done_d;
    logic              busy_d;
    logic              rdy_d;
    logic [ADDR_W-1:0] addr_d;

    assign op          = op_e'(cmd_op);
    assign xfer        = cmd_valid && cmd_ready;
    assign run_cmd     = xfer && (op == OP_PRE_OP || op == OP_BURST);
    assign need_settle = dirty && (SETTLE_CYCLES > 0);

`ifdef BL_SEQ_ABORT_EN
    assign abort_req = cmd_abort;
`else
    assign abort_req = 1'b0;
`endif

    assign abort_hit = abort_req &&
        (state == S_SETTLE || state == S_PRE || state == S_WRITE);
    assign settle_clr = (state == S_SETTLE) && (cnt == '0) && !abort_hit;

    bl_dac_code_bank u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (xfer && op == OP_LOAD),
        .lane      (cmd_lane),
        .code      (cmd_code),
        .dirty_set (xfer && op == OP_LOAD),
        .dirty_clr (settle_clr),
        .codes     (dac_code),
        .dirty     (dirty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (xfer && op == OP_PRE_OP) begin
                    state_nx = need_settle ? S_SETTLE : S_PRE;
                end else if (xfer && op == OP_BURST) begin
                    state_nx = need_settle ? S_SETTLE : S_WRITE;
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nx = lat_burst ? S_WRITE : S_PRE;
                end
            end
            S_PRE:   state_nx = S_DONE;
            S_WRITE: begin
                if (rem == '0) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nx = S_IDLE;
        end
    end

    // Command context is captured once at transfer and consumed by later states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            lat_burst <= 1'b0;
            start     <= '0;
            rem       <= '0;
        end else if (run_cmd) begin
            cnt       <= SETTLE_LD;
            lat_burst <= (op == OP_BURST);
            start     <= cmd_addr;
            rem       <= cmd_len;
        end else begin
            if (state == S_SETTLE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == S_WRITE && rem != '0) begin
                rem <= rem - ADDR_W'(1);
            end
        end
    end

    always_comb begin
        pre_d  = (state_nx == S_PRE);
        wr_d   = (state_nx == S_WRITE);
        done_d = (state_nx == S_DONE);
        busy_d = (state_nx != S_IDLE);
        rdy_d  = (state_nx == S_IDLE);
        addr_d = addr;
        if (wr_d) begin
            if (state == S_WRITE) begin
                addr_d = addr + ADDR_W'(1);
            end else if (state == S_IDLE) begin
                addr_d = cmd_addr;
            end else begin
                addr_d = start;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_pre_op_en <= 1'b0;
            bl_addr_en   <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            cmd_ready    <= 1'b1;
            addr         <= '0;
        end else begin
            bl_pre_op_en <= pre_d;
            bl_addr_en   <= wr_d;
            done         <= done_d;
            busy         <= busy_d;
            cmd_ready    <= rdy_d;
            addr         <= addr_d;
        end
    end

`ifdef BL_SEQ_ABORT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            abort_ack <= 1'b0;
        end else begin
            abort_ack <= abort_hit;
        end
    end
`endif

endmodule

// File: doc/bl_write_sequencer.md
# bl_write_sequencer

Command sequencer directly upstream of the bitline interface stage. Holds the eight 8-bit DAC codes that generate the `op_vol[8]` drive levels. Accepts load, pre-op and burst-write commands over a valid/ready handshake. Produces the `bl_addr_en`, `bl_pre_op_en` and `addr[4:0]` controls for the 32-bitline block, and inserts a DAC settling delay whenever codes have changed.

## Interface
Parameters:
- SETTLE_CYCLES, 4, cycles to wait after a DAC code change before any enable; 0 legal (no wait)
- CNT_W, $clog2(SETTLE_CYCLES+1) (min 1), settle counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept; reset 1
- cmd_op  in  2  00 NOP, 01 LOAD, 10 PRE_OP, 11 BURST
- cmd_lane  in  3  LOAD: DAC lane 0–7
- cmd_code  in  8  LOAD: DAC code
- cmd_addr  in  5  BURST: start bitline address (addr[4:3] region, addr[2:0] bit)
- cmd_len  in  5  BURST: write count minus 1 (0 → 1 write, 31 → 32 writes)
- dac_code  out  8×8 packed [7:0][7:0]  DAC code per lane; reset all 0
- bl_pre_op_en  out  1  broadcast write strobe; reset 0
- bl_addr_en  out  1  per-address write strobe; reset 0
- addr  out  5  bitline address; reset 0
- busy  out  1  high in any state except IDLE; reset 0
- done  out  1  one-cycle pulse when PRE_OP/BURST completes; reset 0

## Operation
- Handshake: transfer when cmd_valid && cmd_ready. cmd_ready = (state == IDLE). Command fields are sampled only at transfer.
- NOP: accepted, no effect, no done.
- LOAD: dac_code[cmd_lane] <= cmd_code at the transfer edge. Sets the dirty flag. Stays in IDLE, so back-to-back LOADs are allowed every cycle.
- PRE_OP: if dirty → SETTLE, else → PRE. PRE drives bl_pre_op_en=1 for exactly one cycle, then → DONE.
- BURST: latch start address and remaining count. If dirty → SETTLE, else → WRITE. WRITE drives bl_addr_en=1 every cycle with addr = start+k. The address wraps 31→0 (5-bit modulo add). After cmd_len+1 cycles → DONE.
- SETTLE: counter loads SETTLE_CYCLES-1 and decrements to 0, then → PRE or WRITE as latched. Leaving SETTLE clears dirty. With SETTLE_CYCLES=0, dirty is ignored and SETTLE is never entered.
- DONE: done=1 for one cycle → IDLE.
- bl_pre_op_en and bl_addr_en are never high in the same cycle.
- Reset mid-operation: the FSM returns to IDLE immediately. All outputs go to their reset values, dac_code clears to 0 and dirty clears.
- Outputs are registered; addr holds its last value when no enable is active.

## Timing
- Transfer at edge T, clean: the first enable is high in cycle T+1.
- Transfer at edge T, dirty: the first enable is high in cycle T+1+SETTLE_CYCLES.
- PRE_OP total latency to done: 2 cycles clean, 2+SETTLE_CYCLES dirty.
- BURST: enables occupy cmd_len+1 consecutive cycles. done is in the cycle after the last enable. cmd_ready rises in the cycle after done.
- A LOAD transferred in the same cycle as a PRE_OP is impossible, because only one command transfers per cycle.

## Configuration
- BL_SEQ_ABORT_EN defined: adds input `cmd_abort` (1 bit).
  - In SETTLE, PRE or WRITE, abort takes the FSM to IDLE on the next edge. The enable outputs are 0 from that edge onward.
  - No done pulse; an `abort_ack` output (1 bit, reset 0) pulses for one cycle instead.
  - dirty is preserved if SETTLE was not completed.
  - Abort in IDLE or DONE is ignored.
- Undefined: neither port exists, and every command runs to completion.

## Structure
- Package bl_pkg:
  - opcode enum (NOP/LOAD/PRE_OP/BURST)
  - FSM state enum (IDLE/SETTLE/PRE/WRITE/DONE)
  - NUM_LANES=8, NUM_BL=32, ADDR_W=5, CODE_W=8
- Sub-module bl_dac_code_bank: 8×8 code register file with write port (lane, code, we) and async-reset clear. It also outputs the dirty flag with a set input (LOAD) and a clear input (SETTLE exit).

## Test plan
- Reset, then LOAD lane3=0xA5 → dac_code[3]=0xA5, others 0, cmd_ready stays 1, busy 0.
- SETTLE_CYCLES=4: LOAD, then PRE_OP at T → bl_pre_op_en high only in cycle T+5, done at T+6, a second PRE_OP (clean) gives bl_pre_op_en at T'+1.
- Clean BURST cmd_addr=30, cmd_len=3 → bl_addr_en high 4 cycles with addr 30,31,0,1, then done, never bl_pre_op_en.
- Burst with cmd_len=31 from addr 0 → all 32 addresses in order, cmd_ready low throughout until after done.
- rst_n asserted mid-BURST at addr 5 → bl_addr_en, addr, busy, done and dac_code all 0 immediately, cmd_ready 1 after release.
- (BL_SEQ_ABORT_EN) abort during WRITE at addr 2 → no further enables, abort_ack pulse, no done, IDLE next cycle.
